// File: rtl/pipelined_tree_multiplier_if.sv
// pipelined_tree_multiplier_if: operand/result valid-ready bundle for the tree multiplier
interface pipelined_tree_multiplier_if #(
  parameter int N = 8
);
  logic in_valid;
  logic in_ready;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic sgn_in;
  logic acc_in;
  logic out_valid;
  logic out_ready;
  logic [2*N-1:0] P_out;
  modport master (
    output in_valid, a_in, b_in, sgn_in, acc_in, out_ready,
    input  in_ready, out_valid, P_out
  );
  modport slave (
    input  in_valid, a_in, b_in, sgn_in, acc_in, out_ready,
    output in_ready, out_valid, P_out
  );
endinterface

// File: rtl/pipelined_tree_multiplier.sv
// pipelined_tree_multiplier: N x N multiplier on a balanced partial-product adder tree with valid/ready stalls and optional accumulate
module pipelined_tree_multiplier #(
  parameter int N = 8,
  parameter int PIPE = 1
) (
  input logic clk,
  input logic Reset,
  pipelined_tree_multiplier_if.slave bus
);
  localparam int W = 2 * N;
  localparam int L = $clog2(W);
  localparam int P2 = 1 << L;
  logic stall, v0, acc0;
  logic [W-1:0] a0, b0;
  assign stall = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;
  // operands are extended to 2N at capture so the tree never needs to know the mode
  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      v0 <= 1'b0;
      acc0 <= 1'b0;
      a0 <= '0;
      b0 <= '0;
    end else if (!stall) begin
      v0 <= bus.in_valid;
      acc0 <= bus.acc_in;
      a0 <= {{N{bus.sgn_in && bus.a_in[N-1]}}, bus.a_in};
      b0 <= {{N{bus.sgn_in && bus.b_in[N-1]}}, bus.b_in};
    end
  // level 0 holds partial products; level l sums pairs; levels 1..PIPE and the root are registered
  for (genvar l = 0; l <= L; l++) begin : lv
    logic [W-1:0] node [P2>>l];
    logic v, acc;
    if (l == 0) begin : g
      logic [P2-1:0] bp;
      assign bp = P2'(b0);
      always_comb
        for (int j = 0; j < P2; j++) node[j] = bp[j] ? a0 << j : '0;
      assign v = v0;
      assign acc = acc0;
    end else begin : g
      logic [W-1:0] s [P2>>l];
      always_comb
        for (int j = 0; j < (P2 >> l); j++) s[j] = lv[l-1].node[2*j] + lv[l-1].node[2*j+1];
      if (l <= PIPE || l == L) begin : r
        always_ff @(posedge clk or posedge Reset)
          if (Reset) begin
            v <= 1'b0;
            acc <= 1'b0;
            node <= '{default: '0};
          end else if (!stall) begin
            v <= lv[l-1].v;
            acc <= lv[l-1].acc;
            node <= s;
          end
      end else begin : c
        assign v = lv[l-1].v;
        assign acc = lv[l-1].acc;
        assign node = s;
      end
    end
  end
  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      bus.out_valid <= 1'b0;
      bus.P_out <= '0;
    end else if (!stall) begin
      bus.out_valid <= lv[L].v;
      if (lv[L].v) bus.P_out <= lv[L].acc ? bus.P_out + lv[L].node[0] : lv[L].node[0];
    end
endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// tb_pipelined_tree_multiplier: directed and randomized checks of the tree multiplier against an arithmetic model
module tb_pipelined_tree_multiplier;
  logic clk = 1'b0;
  logic Reset = 1'b1;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  pipelined_tree_multiplier_if #(.N(8)) m ();
  pipelined_tree_multiplier #(.N(8), .PIPE(1)) dut (.clk(clk), .Reset(Reset), .bus(m.slave));
  logic sv = 1'b0, ssg = 1'b0, sac = 1'b0;
  logic [15:0] sa = '0, sbv = '0;
  logic [3:0] sov;
  logic [3:0][31:0] sp;
  for (genvar p = 0; p < 4; p++) begin : sw
    pipelined_tree_multiplier_if #(.N(16)) s ();
    assign s.in_valid = sv;
    assign s.a_in = sa;
    assign s.b_in = sbv;
    assign s.sgn_in = ssg;
    assign s.acc_in = sac;
    assign s.out_ready = 1'b1;
    assign sov[p] = s.out_valid;
    assign sp[p] = s.P_out;
    pipelined_tree_multiplier #(.N(16), .PIPE(p)) dut (.clk(clk), .Reset(Reset), .bus(s.slave));
  end
  function automatic logic [63:0] mref(int n, logic [63:0] a, logic [63:0] b, bit sg);
    longint x, y;
    logic [63:0] msk;
    x = longint'(a);
    y = longint'(b);
    if (sg && a[n-1]) x -= longint'(1) << n;
    if (sg && b[n-1]) y -= longint'(1) << n;
    msk = (64'd1 << (2 * n)) - 64'd1;
    return 64'(x * y) & msk;
  endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic one(input logic [7:0] a, input logic [7:0] b, input bit sg, input bit ac,
                     input logic [15:0] exp, input string tag);
    int n;
    m.in_valid = 1'b1;
    m.a_in = a;
    m.b_in = b;
    m.sgn_in = sg;
    m.acc_in = ac;
    tick;
    m.in_valid = 1'b0;
    n = 0;
    while (!m.out_valid && n < 10) begin
      tick;
      n++;
    end
    chk({tag, ".v"}, 64'(m.out_valid), 64'd1);
    chk(tag, 64'(m.P_out), 64'(exp));
    tick;
  endtask
  logic [15:0] mlast, prevp;
  logic [63:0] e;
  logic [31:0] slast;
  logic [15:0] q[$];
  bit prev_stall;
  int sent, got, idx;
  bit bv[200];
  logic [31:0] ex[200];
  initial begin
    m.in_valid = 1'b0;
    m.a_in = '0;
    m.b_in = '0;
    m.sgn_in = 1'b0;
    m.acc_in = 1'b0;
    m.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
    tick;
    chk("rst.v", 64'(m.out_valid), 64'd0);
    chk("rst.rdy", 64'(m.in_ready), 64'd1);
    chk("rst.p", 64'(m.P_out), 64'd0);
    // T1: exact latency of PIPE+2 edges after the accepting edge
    m.in_valid = 1'b1;
    m.a_in = 8'hFF;
    m.b_in = 8'hFF;
    tick;
    m.in_valid = 1'b0;
    chk("t1.lat0", 64'(m.out_valid), 64'd0);
    tick;
    chk("t1.lat1", 64'(m.out_valid), 64'd0);
    tick;
    chk("t1.lat2", 64'(m.out_valid), 64'd0);
    tick;
    chk("t1.lat3", 64'(m.out_valid), 64'd1);
    chk("t1.p", 64'(m.P_out), 64'hFE01);
    tick;
    chk("t1.drop", 64'(m.out_valid), 64'd0);
    chk("t1.keep", 64'(m.P_out), 64'hFE01);
    one(8'h80, 8'h80, 1'b1, 1'b0, 16'h4000, "t2.nn");
    one(8'h80, 8'h7F, 1'b1, 1'b0, 16'hC080, "t2.np");
    one(8'h80, 8'h80, 1'b0, 1'b0, 16'h4000, "t2.uu");
    one(8'd3, 8'd4, 1'b0, 1'b0, 16'd12, "t3.a");
    one(8'd5, 8'd6, 1'b0, 1'b1, 16'd42, "t3.b");
    one(8'd2, 8'd2, 1'b0, 1'b1, 16'd46, "t3.c");
    one(8'd0, 8'd0, 1'b0, 1'b0, 16'd0, "t3.z");
    one(8'hFF, 8'd1, 1'b1, 1'b1, 16'hFFFF, "t3.wrap");
    // T4: random beats under alternating backpressure
    mlast = 16'hFFFF;
    sent = 0;
    got = 0;
    prev_stall = 1'b0;
    prevp = '0;
    for (int c = 0; c < 200 && got < 8; c++) begin
      if (prev_stall) begin
        chk("t4.hold_v", 64'(m.out_valid), 64'd1);
        chk("t4.hold_p", 64'(m.P_out), 64'(prevp));
      end
      m.out_ready = (c % 2) == 0;
      m.in_valid = sent < 8;
      m.a_in = 8'($urandom);
      m.b_in = 8'($urandom);
      m.sgn_in = 1'($urandom_range(1));
      m.acc_in = 1'($urandom_range(1));
      #1;
      chk("t4.rdy", 64'(m.in_ready), 64'(!(m.out_valid && !m.out_ready)));
      if (m.in_valid && m.in_ready) begin
        e = mref(8, 64'(m.a_in), 64'(m.b_in), m.sgn_in);
        if (m.acc_in) e = e + 64'(mlast);
        mlast = 16'(e);
        q.push_back(mlast);
        sent++;
      end
      if (m.out_valid && m.out_ready) begin
        chk("t4.q", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) chk("t4.data", 64'(m.P_out), 64'(q.pop_front()));
        got++;
      end
      prev_stall = m.out_valid && !m.out_ready;
      prevp = m.P_out;
      tick;
    end
    m.in_valid = 1'b0;
    m.out_ready = 1'b1;
    chk("t4.count", 64'(got), 64'd8);
    tick;
    tick;
    chk("t4.nodup", 64'(m.out_valid), 64'd0);
    // T5: asynchronous reset with two beats in flight
    m.in_valid = 1'b1;
    m.a_in = 8'd7;
    m.b_in = 8'd9;
    m.acc_in = 1'b0;
    tick;
    m.a_in = 8'd11;
    tick;
    m.in_valid = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk("t5.v", 64'(m.out_valid), 64'd0);
    chk("t5.p", 64'(m.P_out), 64'd0);
    @(negedge clk);
    Reset = 1'b0;
    tick;
    chk("t5.rdy", 64'(m.in_ready), 64'd1);
    for (int c = 0; c < 6; c++) begin
      chk("t5.stale", 64'(m.out_valid), 64'd0);
      tick;
    end
    one(8'd3, 8'd3, 1'b0, 1'b1, 16'd9, "t5.acc0");
    // T6: N=16 with PIPE 0..3 fed identical random beats
    slast = '0;
    for (int t = 0; t < 200; t++) begin
      sv = (t < 190) && ($urandom_range(3) != 0);
      sa = (t % 17 == 0) ? 16'h8000 : 16'($urandom);
      sbv = (t % 17 == 0) ? 16'h8000 : 16'($urandom);
      ssg = 1'($urandom_range(1));
      sac = $urandom_range(3) == 0;
      bv[t] = sv;
      ex[t] = '0;
      if (sv) begin
        e = mref(16, 64'(sa), 64'(sbv), ssg);
        if (sac) e = e + 64'(slast);
        slast = 32'(e);
        ex[t] = slast;
      end
      tick;
      for (int p = 0; p < 4; p++) begin
        idx = t - p - 2;
        if (idx >= 0 && bv[idx]) begin
          chk($sformatf("t6.p%0d.v", p), 64'(sov[p]), 64'd1);
          chk($sformatf("t6.p%0d.data", p), 64'(sp[p]), 64'(ex[idx]));
        end else chk($sformatf("t6.p%0d.idle", p), 64'(sov[p]), 64'd0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
